// File: rtl/icache_line_fill_if.sv
// Refill request/response signals towards the I-cache and the memory read bus.
// The refill engine takes the master view and the testbench or system takes the slave view.
interface icache_line_fill_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 8
);
    logic                       m_strobe;
    logic [ADDR_WIDTH-1:0]      m_addr;
    logic                       m_ready;
    logic [LINE_WORDS*32-1:0]   m_dout;
    logic                       fill_err;
    logic                       busy;
    logic                       bus_req_valid;
    logic                       bus_req_ready;
    logic [ADDR_WIDTH-1:0]      bus_req_addr;
    logic                       bus_rsp_valid;
    logic [31:0]                bus_rsp_data;
    logic                       bus_rsp_err;

    modport master (
        input  m_strobe, m_addr, bus_req_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_err,
        output m_ready, m_dout, fill_err, busy, bus_req_valid, bus_req_addr
    );

    modport slave (
        output m_strobe, m_addr, bus_req_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_err,
        input  m_ready, m_dout, fill_err, busy, bus_req_valid, bus_req_addr
    );
endinterface

// File: rtl/icache_line_fill.sv
// I-cache line refill engine: issues LINE_WORDS pipelined word reads with a bounded
// number in flight, assembles the returned beats into one line (offset-0 word in
// the MSBs) and hands it back to the I-cache with a single-cycle m_ready pulse.
module icache_line_fill #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 8,
    parameter int MAX_OUTST  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    icache_line_fill_if.master bus
);
    localparam int IW = $clog2(LINE_WORDS);
    localparam int CW = IW + 1;
    localparam int OB = IW + 2;

    // DRAIN is the abort path: the requester went away, but beats already in flight
    // must still be absorbed before a new request may be accepted.
    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        RESP,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]         rsp_cnt_q, rsp_cnt_d;
    logic                  err_q, err_d;
    logic [31:0]           line_q [LINE_WORDS];
    logic [31:0]           line_d [LINE_WORDS];

    logic                  req_valid;
    logic                  rsp_accept;
    logic [CW-1:0]         outstanding;
    logic                  addr_offset_unused;

    // The in-line offset bits of the request address carry no information for a refill.
    assign addr_offset_unused = ^bus.m_addr[OB-1:0];

    // Next-state logic: request issue, beat capture and request/abort handshake with the I-cache.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        err_d       = err_q;
        line_d      = line_q;
        req_valid   = 1'b0;
        outstanding = issue_cnt_q - rsp_cnt_q;

        // A beat with nothing outstanding is a bus protocol error and is dropped.
        rsp_accept  = bus.bus_rsp_valid && (rsp_cnt_q != issue_cnt_q) &&
                      ((state_q == FILL) || (state_q == DRAIN));

        if (rsp_accept) begin
            line_d[rsp_cnt_q[IW-1:0]] = bus.bus_rsp_data;
            err_d                     = err_q | bus.bus_rsp_err;
            rsp_cnt_d                 = rsp_cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.m_strobe) begin
                    base_d      = {bus.m_addr[ADDR_WIDTH-1:OB], {OB{1'b0}}};
                    issue_cnt_d = '0;
                    rsp_cnt_d   = '0;
                    err_d       = 1'b0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                req_valid = bus.m_strobe &&
                            (issue_cnt_q < CW'(LINE_WORDS)) &&
                            (outstanding < CW'(MAX_OUTST));
                if (req_valid && bus.bus_req_ready) begin
                    issue_cnt_d = issue_cnt_q + CW'(1);
                end
                if (rsp_accept && (rsp_cnt_q == CW'(LINE_WORDS - 1))) begin
                    state_d = RESP;
                end else if (!bus.m_strobe) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rsp_cnt_q == issue_cnt_q) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                state_d = DONE;
            end
            DONE: begin
                if (!bus.m_strobe) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, base address and line buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            rsp_cnt_q   <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            err_q       <= err_d;
            line_q      <= line_d;
        end
    end

    assign bus.bus_req_valid = req_valid;
    assign bus.bus_req_addr  = base_q + ADDR_WIDTH'({issue_cnt_q, 2'b00});
    assign bus.m_ready       = (state_q == RESP);
    assign bus.fill_err      = (state_q == RESP) && err_q;
    assign bus.busy          = (state_q != IDLE);

    // Pack the line buffer so that beat k lands at word position k counted from the MSB end.
    always_comb begin
        bus.m_dout = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            bus.m_dout[(LINE_WORDS-k)*32-1 -: 32] = line_q[k];
        end
    end
endmodule
